// File: rtl/i2s_pkg.sv
// Shared I2S constants and types for the transmit and receive paths.
// All I2S clocks are derived from one 9-bit divider of the system clock.
package i2s_pkg;

  localparam int unsigned CNT_W    = 9;
  localparam int unsigned SLOT_W   = 32;
  localparam int unsigned MCLK_BIT = 0;
  localparam int unsigned SCLK_BIT = 2;
  localparam int unsigned LRCK_BIT = 8;

  typedef enum logic {
    CHAN_LEFT  = 1'b0,
    CHAN_RIGHT = 1'b1
  } chan_e;

endpackage

// File: rtl/i2s_clk_gen.sv
// Free-running divider producing mclk/sclk/lrck from flops, plus frame and bit-update
// strobes and the slot/channel that the next count value addresses.
module i2s_clk_gen
  import i2s_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         rst_ni,
  output logic                         mclk_o,
  output logic                         sclk_o,
  output logic                         lrck_o,
  output logic                         frame_start_o,
  output logic                         sdout_update_o,
  output logic [LRCK_BIT-SCLK_BIT-2:0] next_slot_o,
  output logic                         next_chan_o
);

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             mclk_q, sclk_q, lrck_q;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
  end

  // Clock pins come from their own flops, loaded from the next count, so they track cnt_q.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      mclk_q <= 1'b0;
      sclk_q <= 1'b0;
      lrck_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mclk_q <= cnt_d[MCLK_BIT];
      sclk_q <= cnt_d[SCLK_BIT];
      lrck_q <= cnt_d[LRCK_BIT];
    end
  end

  assign mclk_o         = mclk_q;
  assign sclk_o         = sclk_q;
  assign lrck_o         = lrck_q;
  assign frame_start_o  = &cnt_q;
  assign sdout_update_o = &cnt_q[SCLK_BIT:0];
  assign next_slot_o    = cnt_d[LRCK_BIT-1:SCLK_BIT+1];
  assign next_chan_o    = cnt_d[LRCK_BIT];

endmodule

// File: rtl/i2s_axis_tx.sv
// AXI-Stream to I2S serializer: buffers one L/R pair, loads it at each frame boundary
// and shifts it out MSB first in 32-bit I2S slots.
module i2s_axis_tx
  import i2s_pkg::*;
#(
  parameter int unsigned WIDTH_P = 24
) (
  input  logic               axis_clk,
  input  logic               axis_resetn,
  input  logic [WIDTH_P-1:0] tx_axis_c_data,
  input  logic               tx_axis_c_valid,
  output logic               tx_axis_c_ready,
  input  logic               tx_axis_c_last,
  output logic               tx_mclk,
  output logic               tx_lrck,
  output logic               tx_sclk,
  output logic               tx_sdout,
  output logic               underrun_o,
  output logic               misalign_o
);

  logic                         frame_start, sdout_update, next_chan;
  logic [LRCK_BIT-SCLK_BIT-2:0] next_slot;

  i2s_clk_gen u_clk_gen (
    .clk_i          (axis_clk),
    .rst_ni         (axis_resetn),
    .mclk_o         (tx_mclk),
    .sclk_o         (tx_sclk),
    .lrck_o         (tx_lrck),
    .frame_start_o  (frame_start),
    .sdout_update_o (sdout_update),
    .next_slot_o    (next_slot),
    .next_chan_o    (next_chan)
  );

  chan_e              expect_d, expect_q;
  logic [WIDTH_P-1:0] hold_l_d, hold_l_q, hold_r_d, hold_r_q;
  logic [WIDTH_P-1:0] frame_l_d, frame_l_q, frame_r_d, frame_r_q;
  logic               l_vld_d, l_vld_q, r_vld_d, r_vld_q;
  logic               sdout_d, sdout_q, underrun_d, underrun_q, misalign_q, run_q;
  logic               accept, wr_l, wr_r, mis_beat;
  logic [WIDTH_P-1:0] word;
  logic [SLOT_W-1:0]  slot_word;

  assign tx_axis_c_ready = run_q & ~(l_vld_q & r_vld_q);
  assign accept          = tx_axis_c_valid & tx_axis_c_ready;

  always_ff @(posedge axis_clk or negedge axis_resetn) begin
    if (!axis_resetn) expect_q <= CHAN_LEFT;
    else              expect_q <= expect_d;
  end

  // Any left beat leaves us waiting for its right partner; any right beat resets to left.
  always_comb begin
    expect_d = expect_q;
    if (accept) expect_d = tx_axis_c_last ? CHAN_LEFT : CHAN_RIGHT;
  end

  always_comb begin
    wr_l     = 1'b0;
    wr_r     = 1'b0;
    mis_beat = 1'b0;
    if (accept) begin
      unique case (expect_q)
        CHAN_LEFT: begin
          wr_l     = ~tx_axis_c_last;
          mis_beat = tx_axis_c_last;
        end
        CHAN_RIGHT: begin
          wr_l     = ~tx_axis_c_last;
          wr_r     = tx_axis_c_last;
          mis_beat = ~tx_axis_c_last;
        end
        default: ;
      endcase
    end
  end

  // Load never collides with a write: ready is low whenever the pair is full.
  always_comb begin
    hold_l_d   = hold_l_q;
    hold_r_d   = hold_r_q;
    l_vld_d    = l_vld_q;
    r_vld_d    = r_vld_q;
    frame_l_d  = frame_l_q;
    frame_r_d  = frame_r_q;
    underrun_d = 1'b0;
    if (frame_start) begin
      if (l_vld_q & r_vld_q) begin
        frame_l_d = hold_l_q;
        frame_r_d = hold_r_q;
        l_vld_d   = 1'b0;
        r_vld_d   = 1'b0;
      end else begin
        frame_l_d  = '0;
        frame_r_d  = '0;
        underrun_d = 1'b1;
      end
    end
    if (wr_l) begin
      hold_l_d = tx_axis_c_data;
      l_vld_d  = 1'b1;
    end
    if (wr_r) begin
      hold_r_d = tx_axis_c_data;
      r_vld_d  = 1'b1;
    end
  end

  // Slot word is MSB-first with a leading zero, so slot k maps to bit SLOT_W-1-k == ~k.
  always_comb begin
    word      = next_chan ? frame_r_q : frame_l_q;
    slot_word = {{(SLOT_W - WIDTH_P){1'b0}}, word} << (SLOT_W - 1 - WIDTH_P);
    sdout_d   = sdout_update ? slot_word[~next_slot] : sdout_q;
  end

  always_ff @(posedge axis_clk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      hold_l_q   <= '0;
      hold_r_q   <= '0;
      l_vld_q    <= 1'b0;
      r_vld_q    <= 1'b0;
      frame_l_q  <= '0;
      frame_r_q  <= '0;
      sdout_q    <= 1'b0;
      underrun_q <= 1'b0;
      misalign_q <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      hold_l_q   <= hold_l_d;
      hold_r_q   <= hold_r_d;
      l_vld_q    <= l_vld_d;
      r_vld_q    <= r_vld_d;
      frame_l_q  <= frame_l_d;
      frame_r_q  <= frame_r_d;
      sdout_q    <= sdout_d;
      underrun_q <= underrun_d;
      misalign_q <= mis_beat;
      run_q      <= 1'b1;
    end
  end

  assign tx_sdout   = sdout_q;
  assign underrun_o = underrun_q;
  assign misalign_o = misalign_q;

endmodule

// File: tb/tb_i2s_axis_tx.sv
// Scoreboard bench for i2s_axis_tx: accepted pairs queue up as expected frames, and a
// negedge monitor checks pins, handshake, pulses and serial bits against the model.
module tb_i2s_axis_tx;

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
  } pair_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_last = 1'b0;
  logic        tx_ready, tx_mclk, tx_lrck, tx_sclk, tx_sdout, underrun, misalign;

  int n_checks = 0;
  int n_err = 0;

  // Reference model state
  logic [8:0]  m_cnt = '0;
  bit          m_run = 0, m_ready = 0, m_under = 0, m_mis = 0, m_acc = 0;
  bit          m_pend_v = 0;
  logic [23:0] m_pend = '0;
  logic [23:0] cur_l = '0, cur_r = '0;
  pair_t       pair_q[$];

  i2s_axis_tx #(.WIDTH_P(24)) dut (
    .axis_clk        (clk),
    .axis_resetn     (rst_n),
    .tx_axis_c_data  (tx_data),
    .tx_axis_c_valid (tx_valid),
    .tx_axis_c_ready (tx_ready),
    .tx_axis_c_last  (tx_last),
    .tx_mclk         (tx_mclk),
    .tx_lrck         (tx_lrck),
    .tx_sclk         (tx_sclk),
    .tx_sdout        (tx_sdout),
    .underrun_o      (underrun),
    .misalign_o      (misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // I2S slot k of a channel carries data[24-k] for k=1..24, zero otherwise.
  function automatic logic exp_bit(input logic [8:0] c);
    int          k;
    logic [23:0] w;
    k = int'(c[7:3]);
    w = c[8] ? cur_r : cur_l;
    if (k >= 1 && k <= 24) return w[24-k];
    return 1'b0;
  endfunction

  // Behavioural model: a pending left sample plus a queue of complete pairs.
  initial begin
    pair_t p;
    bit    nu, nm;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_cnt = '0; m_run = 0; m_ready = 0; m_under = 0; m_mis = 0; m_acc = 0;
        m_pend_v = 0; cur_l = '0; cur_r = '0;
        pair_q.delete();
      end else begin
        nu = 0;
        nm = 0;
        if (m_cnt == 9'd511) begin
          if (pair_q.size() > 0) begin
            p = pair_q.pop_front();
            cur_l = p.l;
            cur_r = p.r;
          end else begin
            cur_l = '0;
            cur_r = '0;
            nu = 1;
          end
        end
        m_acc = tx_valid && m_ready;
        if (m_acc) begin
          if (!tx_last) begin
            if (m_pend_v) nm = 1;
            m_pend = tx_data;
            m_pend_v = 1;
          end else if (m_pend_v) begin
            p.l = m_pend;
            p.r = tx_data;
            pair_q.push_back(p);
            m_pend_v = 0;
          end else begin
            nm = 1;
          end
        end
        m_cnt = m_cnt + 9'd1;
        m_run = 1;
        m_ready = (pair_q.size() == 0);
        m_under = nu;
        m_mis = nm;
      end
    end
  end

  // Monitor
  initial begin
    logic [5:0] got_v, exp_v;
    forever begin
      @(negedge clk);
      exp_v = {m_cnt[0], m_cnt[2], m_cnt[8], m_ready, m_under, m_mis};
      got_v = {tx_mclk, tx_sclk, tx_lrck, tx_ready, underrun, misalign};
      check("mclk_sclk_lrck_ready_under_mis", 32'(got_v), 32'(exp_v));
      if (!rst_n) check("sdout_in_reset", 32'(tx_sdout), 32'd0);
      else if (m_cnt[2:0] == 3'd4) check("sdout_bit", 32'(tx_sdout), 32'(exp_bit(m_cnt)));
    end
  end

  task automatic send(input logic [23:0] d, input logic l);
    int n = 0;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    tx_last  = l;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!m_acc && n < 3000);
    check("beat_accepted", 32'(m_acc), 32'd1);
    tx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cnt(input logic [8:0] v);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (m_cnt != v && n < 2000);
    check("wait_cnt_reached", 32'(m_cnt), 32'(v));
  endtask

  initial begin
    #(80000 * 10);
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    // Reset and free-running clocks
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    idle(600);

    // Fixed pair, then four back-to-back beats
    send(24'hA5A5A5, 1'b0);
    send(24'h5A5A5A, 1'b1);
    idle(1100);
    for (int i = 0; i < 4; i++) send(24'($urandom), 1'(i % 2));
    idle(1600);

    // Three idle frames
    idle(3 * 512);

    // Misordered right first, then a good pair
    send(24'h123456, 1'b1);
    send(24'h000001, 1'b0);
    send(24'h800000, 1'b1);
    idle(1200);

    // Randomized beats with occasional order errors and random gaps
    for (int i = 0; i < 40; i++) begin
      send(24'($urandom), 1'(i % 2) ^ 1'($urandom_range(0, 9) == 0));
      idle($urandom_range(0, 300));
    end
    idle(1200);

    // Reset mid-frame with one pair playing and another held
    send(24'hC3C3C3, 1'b0);
    send(24'h3C3C3C, 1'b1);
    wait_cnt(9'd2);
    send(24'h777777, 1'b0);
    send(24'h111111, 1'b1);
    wait_cnt(9'd300);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          32'({tx_mclk, tx_sclk, tx_lrck, tx_ready, tx_sdout, underrun, misalign}), 32'd0);
    idle(4);
    rst_n = 1'b1;
    idle(2 * 512 + 20);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
